// File: rtl/instruction_sequencer.sv
// Instruction sequencer: owns IR and the 2-bit timestep counter that feed the
// processor controller, adds run/stop control, a retire pulse and counter, and
// a sticky fault flag for instructions that overrun timestep 11 without Clr.
module instruction_sequencer #(
    parameter int IR_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run,
    input  logic             stop,
    input  logic [IR_W-1:0]  bus,
    input  logic             IRin,
    input  logic             Clr,
    output logic [IR_W-1:0]  IR,
    output logic [1:0]       timestep,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] instr_count,
    output logic             fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state, state_n;
    logic              stop_pending, stop_pending_n;
    logic [IR_W-1:0]   ir_n;
    logic [1:0]        ts_n;
    logic              done_n;
    logic [CNT_W-1:0]  cnt_n;
    logic              fault_n;

    // State and every output are registered; outputs only ever reflect state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            stop_pending <= 1'b0;
            IR           <= '0;
            timestep     <= 2'b00;
            busy         <= 1'b0;
            done         <= 1'b0;
            instr_count  <= '0;
            fault        <= 1'b0;
        end else begin
            state        <= state_n;
            stop_pending <= stop_pending_n;
            IR           <= ir_n;
            timestep     <= ts_n;
            busy         <= (state_n == RUN);
            done         <= done_n;
            instr_count  <= cnt_n;
            fault        <= fault_n;
        end
    end

    // Next-state and next-output logic; RUN applies IRin, then Clr, then stepping.
    always_comb begin
        state_n        = state;
        stop_pending_n = stop_pending;
        ir_n           = IR;
        ts_n           = timestep;
        done_n         = 1'b0;
        cnt_n          = instr_count;
        fault_n        = fault;
        case (state)
            IDLE: begin
                ts_n           = 2'b00;
                stop_pending_n = 1'b0;
                if (run) state_n = RUN;
            end
            RUN: begin
                if (IRin) ir_n = bus;
                if (Clr) begin
                    ts_n   = 2'b00;
                    done_n = 1'b1;
                    cnt_n  = instr_count + CNT_W'(1);
                    // A stop seen now or earlier takes effect at this boundary.
                    if (stop || stop_pending) begin
                        state_n        = IDLE;
                        stop_pending_n = 1'b0;
                    end
                end else if (timestep != 2'b11) begin
                    ts_n = timestep + 2'b01;
                    if (stop) stop_pending_n = 1'b1;
                end else begin
                    // Overran the last timestep without Clr: latch the fault and park.
                    fault_n = 1'b1;
                    ts_n    = 2'b00;
                    state_n = HALT;
                    if (stop) stop_pending_n = 1'b1;
                end
            end
            HALT: begin
                ts_n = 2'b00;
            end
            default: begin
                state_n = IDLE;
                ts_n    = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: directed scenarios with literal expectations
// followed by randomized stimulus, all checked against a behavioural model.
module tb_instruction_sequencer;

    localparam int IR_W  = 10;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             resetn, run, stop, IRin, Clr;
    logic [IR_W-1:0]  bus;
    logic [IR_W-1:0]  IR;
    logic [1:0]       timestep;
    logic             busy, done, fault;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    instruction_sequencer #(.IR_W(IR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .run(run), .stop(stop), .bus(bus),
        .IRin(IRin), .Clr(Clr), .IR(IR), .timestep(timestep), .busy(busy),
        .done(done), .instr_count(instr_count), .fault(fault)
    );

    always #5 clk = ~clk;

    // Behavioural model. mode: "idle", "run", "halt" tracked as small ints.
    // steps = number of cycles spent in the current instruction so far.
    int             m_mode;      // 0 idle, 1 run, 2 halt
    int             m_steps;
    int unsigned    m_retired;   // unbounded count, reduced mod 2^CNT_W on compare
    logic [IR_W-1:0] m_ir;
    bit             m_done, m_fault, m_stop_req;

    task automatic model_reset();
        m_mode = 0; m_steps = 0; m_retired = 0; m_ir = '0;
        m_done = 0; m_fault = 0; m_stop_req = 0;
    endtask

    task automatic model_edge();
        if (!resetn) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (m_mode == 0) begin
            m_steps = 0; m_stop_req = 0;
            if (run) m_mode = 1;
        end else if (m_mode == 1) begin
            if (IRin) m_ir = bus;
            m_stop_req = m_stop_req | stop;
            if (Clr) begin
                m_retired++;
                m_done  = 1;
                m_steps = 0;
                if (m_stop_req) begin m_mode = 0; m_stop_req = 0; end
            end else if (m_steps + 1 >= 4) begin
                m_fault = 1; m_steps = 0; m_mode = 2;
            end else begin
                m_steps++;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model.
    task automatic compare_all();
        check("IR",          32'(IR),          32'(m_ir));
        check("timestep",    32'(timestep),    32'(m_steps));
        check("busy",        32'(busy),        32'(m_mode == 1));
        check("done",        32'(done),        32'(m_done));
        check("instr_count", 32'(instr_count), m_retired % (1 << CNT_W));
        check("fault",       32'(fault),       32'(m_fault));
    endtask

    // One clock: apply inputs, advance model at the edge, compare 1 time unit after.
    task automatic step(input logic rn, input logic r, input logic s,
                        input logic [IR_W-1:0] b, input logic ir, input logic c);
        resetn = rn; run = r; stop = s; bus = b; IRin = ir; Clr = c;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int halt_cycles;
        model_reset();
        resetn = 0; run = 0; stop = 0; bus = '0; IRin = 0; Clr = 0;

        // Reset state
        step(0, 0, 0, '0, 0, 0);
        check("rst_ts", 32'(timestep), 0);
        check("rst_cnt", 32'(instr_count), 0);

        // 1. Reset mid-instruction
        step(1, 1, 0, '0, 0, 0);          // -> RUN, ts 00
        step(1, 0, 0, '0, 0, 0);          // ts 01
        step(1, 0, 0, '0, 0, 0);          // ts 10
        check("t1_ts10", 32'(timestep), 2);
        step(0, 0, 0, '0, 0, 0);
        check("t1_busy", 32'(busy), 0);
        check("t1_ts", 32'(timestep), 0);
        step(1, 1, 0, '0, 0, 0);          // restart, ts 00
        check("t1_restart_ts", 32'(timestep), 0);
        check("t1_restart_busy", 32'(busy), 1);

        // 2. Fetch + 4-step instruction
        step(1, 0, 0, 10'h0A8, 1, 0);
        check("t2_ir", 32'(IR), 32'h0A8);
        check("t2_ts1", 32'(timestep), 1);
        step(1, 0, 0, 10'h3FF, 0, 0);
        step(1, 0, 0, 10'h3FF, 0, 0);
        check("t2_ts3", 32'(timestep), 3);
        step(1, 0, 0, 10'h3FF, 0, 1);
        check("t2_done", 32'(done), 1);
        check("t2_ts0", 32'(timestep), 0);
        check("t2_cnt", 32'(instr_count), 1);
        check("t2_ir_hold", 32'(IR), 32'h0A8);

        // 3. Five two-step instructions
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, '0, 0, 0);
            check("t3_ts1", 32'(timestep), 1);
            step(1, 0, 0, '0, 0, 1);
            check("t3_done", 32'(done), 1);
        end
        check("t3_cnt", 32'(instr_count), 6);

        // 4. Stop mid-instruction
        step(1, 0, 0, '0, 0, 0);          // ts 01
        step(1, 0, 1, '0, 0, 0);          // stop at ts 01 -> ts 10
        step(1, 0, 0, '0, 0, 0);          // ts 11
        step(1, 0, 0, '0, 0, 1);          // Clr, stop pending
        check("t4_done", 32'(done), 1);
        check("t4_busy", 32'(busy), 0);
        check("t4_cnt", 32'(instr_count), 7);
        step(1, 0, 0, '0, 1, 1);          // idle ignores strobes
        check("t4_idle_ts", 32'(timestep), 0);
        check("t4_idle_done", 32'(done), 0);
        step(1, 1, 0, '0, 0, 0);
        check("t4_resume", 32'(busy), 1);

        // 5. Missing Clr
        step(1, 0, 0, '0, 0, 0);
        step(1, 0, 0, '0, 0, 0);
        step(1, 0, 0, '0, 0, 0);          // ts 11
        step(1, 0, 0, '0, 0, 0);          // overrun
        check("t5_fault", 32'(fault), 1);
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(done), 0);
        check("t5_cnt", 32'(instr_count), 7);
        step(1, 1, 1, 10'h155, 1, 1);
        step(1, 1, 0, 10'h155, 1, 1);
        check("t5_ir_hold", 32'(IR), 32'h0A8);
        check("t5_stuck_busy", 32'(busy), 0);

        // 6. Counter wrap with CNT_W=4
        step(0, 0, 0, '0, 0, 0);
        step(1, 1, 0, '0, 0, 0);
        for (int i = 0; i < 15; i++) step(1, 0, 0, '0, 0, 1);
        check("t6_cnt15", 32'(instr_count), 15);
        step(1, 0, 0, '0, 0, 1);
        check("t6_wrap", 32'(instr_count), 0);
        check("t6_fault", 32'(fault), 0);

        // Randomized phase
        halt_cycles = 0;
        for (int n = 0; n < 4000; n++) begin
            logic rn;
            rn = !($urandom_range(0, 59) == 0) && (halt_cycles < 6);
            if (!rn) halt_cycles = 0;
            step(rn, $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0,
                 IR_W'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            if (m_mode == 2) halt_cycles++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time bound so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
